// File: rtl/axi8_lite_pkg.sv
// Shared definitions for the 8-bit AXI4-Lite master and slave.
// Provides the master FSM state enum, the AXI response codes and the default
// bus widths.
package axi8_lite_pkg;

  localparam int AXI8_ADDR_W = 1;
  localparam int AXI8_DATA_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WDATA,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_RSP
  } state_t;

endpackage

// File: rtl/axi8_stall_timer.sv
// Saturating 8-bit wait counter for the master's stall watchdog.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   clear - zero the counter (FSM state change)
//   run   - count this cycle (FSM is in a handshake wait state)
//   stall - counter has reached STALL_LIMIT
module axi8_stall_timer #(
  parameter int STALL_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic stall
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (run && cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end

  assign stall = (cnt >= LIMIT);

endmodule

// File: rtl/axi8_lite_master.sv
// Single-outstanding AXI4-Lite master. Converts a cmd/rsp stream into
// serial AW->W->B or AR->R handshakes, keeps wrapping write/read completion
// counters and flags handshakes that wait too long.
// Ports:
//   ACLK, ARESET           - clock, synchronous active-high reset
//   cmd_*                  - command stream (valid/ready, write, addr, wdata)
//   rsp_*                  - response stream (valid/ready, rdata, resp, write)
//   AW*/W*/B*/AR*/R*       - AXI4-Lite master channels
//   wr_count, rd_count     - completed transactions, wrap at 255
//   stall                  - current handshake waited >= STALL_LIMIT cycles
module axi8_lite_master
  import axi8_lite_pkg::*;
#(
  parameter int ADDR_WIDTH  = AXI8_ADDR_W,
  parameter int DATA_WIDTH  = AXI8_DATA_W,
  parameter int STALL_LIMIT = 15
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_write,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic                    BVALID,
  input  logic [1:0]              BRESP,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic                    RVALID,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  output logic                    RREADY,
  output logic [7:0]              wr_count,
  output logic [7:0]              rd_count,
  output logic                    stall
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    accept, b_hs, r_hs, waiting;

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    rsp_valid = 1'b0;
    waiting   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Only combinational input->output path: keep the command port shut
        // while reset is asserted.
        cmd_ready = !ARESET;
        if (cmd_valid && !ARESET) state_d = cmd_write ? ST_WADDR : ST_RADDR;
      end
      ST_WADDR: begin
        AWVALID = 1'b1;
        waiting = 1'b1;
        if (AWREADY) state_d = ST_WDATA;
      end
      ST_WDATA: begin
        WVALID  = 1'b1;
        waiting = 1'b1;
        if (WREADY) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        BREADY  = 1'b1;
        waiting = 1'b1;
        if (BVALID) state_d = ST_RSP;
      end
      ST_RADDR: begin
        ARVALID = 1'b1;
        waiting = 1'b1;
        if (ARREADY) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        RREADY  = 1'b1;
        waiting = 1'b1;
        if (RVALID) state_d = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;
  assign b_hs   = BVALID && BREADY;
  assign r_hs   = RVALID && RREADY;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q    <= '0;
      data_q    <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= RESP_OKAY;
      wr_count  <= '0;
      rd_count  <= '0;
    end else begin
      if (accept) begin
        addr_q    <= cmd_addr;
        data_q    <= cmd_wdata;
        rsp_write <= cmd_write;
      end
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp  <= BRESP;
        wr_count  <= wr_count + 8'd1;
      end
      if (r_hs) begin
        rsp_rdata <= RDATA;
        rsp_resp  <= RRESP;
        rd_count  <= rd_count + 8'd1;
      end
    end
  end

  // Address/data come straight from the command latch, which only changes in
  // IDLE, so they are stable for the whole VALID window.
  assign AWADDR = addr_q;
  assign ARADDR = addr_q;
  assign WDATA  = data_q;
  assign WSTRB  = '1;

  axi8_stall_timer #(.STALL_LIMIT(STALL_LIMIT)) u_stall (
    .clk   (ACLK),
    .rst   (ARESET),
    .clear (state_d != state_q),
    .run   (waiting),
    .stall (stall)
  );

endmodule

// File: tb/tb_axi8_lite_master.sv
// Directed bench for axi8_lite_master against a small inverting slave model:
// reads of address 1 return the bitwise inverse of register 0.
module tb_axi8_lite_master;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [0:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_write;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [0:0] AWADDR, ARADDR;
  logic       AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic       ARVALID, ARREADY, RVALID, RREADY;
  logic [7:0] WDATA, RDATA;
  logic [0:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic [7:0] wr_count, rd_count;
  logic       stall;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi8_lite_master #(.ADDR_WIDTH(1), .DATA_WIDTH(8), .STALL_LIMIT(15)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .wr_count(wr_count), .rd_count(rd_count), .stall(stall)
  );

  // ---------------- slave model ----------------
  logic       aw_rdy = 1'b1;
  logic       w_rdy  = 1'b1;
  logic [1:0] bresp_inj = 2'b00;
  logic [7:0] mem0;
  logic [0:0] aw_addr_s;

  assign AWREADY = aw_rdy;
  assign WREADY  = w_rdy;
  assign ARREADY = 1'b1;
  assign RRESP   = 2'b00;

  always @(posedge ACLK) begin
    if (ARESET) begin
      BVALID <= 1'b0;
      BRESP  <= 2'b00;
      RVALID <= 1'b0;
      RDATA  <= 8'h00;
      mem0   <= 8'h00;
      aw_addr_s <= 1'b0;
    end else begin
      if (AWVALID && AWREADY) aw_addr_s <= AWADDR;
      if (WVALID && WREADY) begin
        if (aw_addr_s == 1'b0) mem0 <= WDATA;
        BVALID <= 1'b1;
        BRESP  <= bresp_inj;
      end else if (BVALID && BREADY) BVALID <= 1'b0;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        RDATA  <= ARADDR[0] ? ~mem0 : mem0;
      end else if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic start_cmd(input logic w, input logic a, input logic [7:0] d);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(posedge ACLK); #1; n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept_timeout cmd_ready=%b expected 1", cmd_ready);
    end
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 100) begin @(posedge ACLK); #1; edges++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout rsp_valid=%b expected 1", rsp_valid);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge ACLK); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY, stall} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 00000000",
               {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY, stall});
    end
    checks++;
    if ({wr_count, rd_count, rsp_rdata, rsp_resp, rsp_write} !== 27'd0) begin
      errors++;
      $display("FAIL reset_data wr=%h rd=%h rdata=%h resp=%b w=%b expected all 0",
               wr_count, rd_count, rsp_rdata, rsp_resp, rsp_write);
    end
    ARESET = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    int e;
    start_cmd(1'b1, 1'b0, 8'h5A);
    wait_rsp(e);
    checks++;
    if (e + 2 != 5) begin errors++; $display("FAIL write_cycles got %0d expected 5", e + 2); end
    checks++;
    if ({rsp_write, rsp_resp, rsp_rdata, wr_count} !== {1'b1, 2'b00, 8'h00, 8'd1}) begin
      errors++;
      $display("FAIL write_rsp w=%b resp=%b rdata=%h wr=%0d expected 1 00 00 1",
               rsp_write, rsp_resp, rsp_rdata, wr_count);
    end
    finish_rsp();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_idle cmd_ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
    start_cmd(1'b0, 1'b1, 8'h00);
    wait_rsp(e);
    checks++;
    if (e + 2 != 4) begin errors++; $display("FAIL read_cycles got %0d expected 4", e + 2); end
    checks++;
    if ({rsp_write, rsp_resp, rsp_rdata, rd_count, wr_count} !== {1'b0, 2'b00, 8'hA5, 8'd1, 8'd1}) begin
      errors++;
      $display("FAIL read_rsp w=%b resp=%b rdata=%h rd=%0d wr=%0d expected 0 00 a5 1 1",
               rsp_write, rsp_resp, rsp_rdata, rd_count, wr_count);
    end
    finish_rsp();
  endtask

  task automatic test_stall();
    int e;
    aw_rdy = 1'b0;
    start_cmd(1'b1, 1'b1, 8'h77);
    checks++;
    if (stall !== 1'b0 || AWVALID !== 1'b1) begin
      errors++;
      $display("FAIL stall_start stall=%b awvalid=%b expected 0 1", stall, AWVALID);
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge ACLK); #1;
      checks++;
      if (AWVALID !== 1'b1 || AWADDR !== 1'b1 || stall !== (i >= 15)) begin
        errors++;
        $display("FAIL stall_wait%0d awvalid=%b awaddr=%b stall=%b expected 1 1 %b",
                 i, AWVALID, AWADDR, stall, (i >= 15));
      end
    end
    aw_rdy = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if (WVALID !== 1'b1 || stall !== 1'b0 || WDATA !== 8'h77) begin
      errors++;
      $display("FAIL stall_clear wvalid=%b stall=%b wdata=%h expected 1 0 77", WVALID, stall, WDATA);
    end
    wait_rsp(e);
    checks++;
    if (rsp_resp !== 2'b00 || wr_count !== 8'd2) begin
      errors++;
      $display("FAIL stall_done resp=%b wr=%0d expected 00 2", rsp_resp, wr_count);
    end
    finish_rsp();
  endtask

  task automatic test_rsp_hold();
    int e;
    start_cmd(1'b1, 1'b0, 8'hC3);
    wait_rsp(e);
    finish_rsp();
    rsp_ready = 1'b0;
    start_cmd(1'b0, 1'b1, 8'h00);
    wait_rsp(e);
    // Offer a new command while the response is parked.
    cmd_write = 1'b1; cmd_addr = 1'b0; cmd_wdata = 8'h11; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C || cmd_ready !== 1'b0 || AWVALID !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d rsp_valid=%b rdata=%h cmd_ready=%b awvalid=%b expected 1 3c 0 0",
                 i, rsp_valid, rsp_rdata, cmd_ready, AWVALID);
      end
      @(posedge ACLK); #1;
    end
    rsp_ready = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release rsp_valid=%b cmd_ready=%b expected 0 1", rsp_valid, cmd_ready);
    end
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    checks++;
    if (AWVALID !== 1'b1) begin
      errors++;
      $display("FAIL hold_next_accept awvalid=%b expected 1", AWVALID);
    end
    wait_rsp(e);
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    w_rdy = 1'b0;
    start_cmd(1'b1, 1'b0, 8'h99);
    @(posedge ACLK); #1;
    checks++;
    if (WVALID !== 1'b1 || wr_count === 8'd0) begin
      errors++;
      $display("FAIL midrst_pre wvalid=%b wr=%0d expected 1 nonzero", WVALID, wr_count);
    end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if ({WVALID, AWVALID, BREADY, rsp_valid, cmd_ready, stall} !== 6'b0 ||
        wr_count !== 8'd0 || rd_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst wv=%b awv=%b br=%b rv=%b cr=%b st=%b wr=%0d rd=%0d expected all 0",
               WVALID, AWVALID, BREADY, rsp_valid, cmd_ready, stall, wr_count, rd_count);
    end
    w_rdy = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_release cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_wrap();
    int e;
    for (int i = 0; i < 256; i++) begin
      bresp_inj = (i == 255) ? 2'b10 : 2'b00;
      start_cmd(1'b1, 1'b0, 8'(i));
      wait_rsp(e);
      if (i == 254) begin
        checks++;
        if (wr_count !== 8'd255 || rsp_resp !== 2'b00) begin
          errors++;
          $display("FAIL wrap_255 wr=%0d resp=%b expected 255 00", wr_count, rsp_resp);
        end
      end
      if (i == 255) begin
        checks++;
        if (wr_count !== 8'd0 || rsp_resp !== 2'b10 || rsp_rdata !== 8'h00) begin
          errors++;
          $display("FAIL wrap_0 wr=%0d resp=%b rdata=%h expected 0 10 00", wr_count, rsp_resp, rsp_rdata);
        end
      end
      finish_rsp();
    end
    bresp_inj = 2'b00;
  endtask

  initial begin
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 1'b0;
    cmd_wdata = 8'h00; rsp_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_rsp_hold();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
